ex_stage: RTL and testbench

EX_STAGE -- requirements
Module: ex_stage

---
 rtl/ex_stage.sv | 200 ++++++++++++++++++++
 tb/tb_ex_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// ex_stage: execute stage with ALU, operand bypass and registered writeback.
// Define QTPA_MUL_EN to build in the iterative shift-add multiplier and stall.
package qtpa_pkg;
    parameter int DATA_WIDTH = 32;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_SHL = 4'd6,
        OP_SHR = 4'd7,
        OP_MUL = 4'd8
    } op_t;
endpackage

module ex_stage
    import qtpa_pkg::*;
#(
    parameter int DATA_WIDTH = qtpa_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  op_t                   ex_alu_op,
    input  logic [3:0]            ex_rd_addr,
    input  logic                  ex_we,
    input  logic [DATA_WIDTH-1:0] ex_imm_ext,
    input  logic                  ex_use_imm,
    input  logic [DATA_WIDTH-1:0] ex_rs1_data,
    input  logic [DATA_WIDTH-1:0] ex_rs2_data,
    input  logic [3:0]            ex_rs1_addr,
    input  logic [3:0]            ex_rs2_addr,
    input  logic                  fwd_we,
    input  logic [3:0]            fwd_addr,
    input  logic [DATA_WIDTH-1:0] fwd_data,
    output logic                  ex_busy,
    output logic [DATA_WIDTH-1:0] wb_result,
    output logic [3:0]            wb_rd_addr,
    output logic                  wb_we
);

    localparam int SW = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_wb_result;
    logic [3:0]            r_wb_rd;
    logic                  r_wb_we;

    logic [DATA_WIDTH-1:0] w_op_a;
    logic [DATA_WIDTH-1:0] w_rs2_fwd;
    logic [DATA_WIDTH-1:0] w_op_b;
    logic [DATA_WIDTH-1:0] w_alu;
    logic                  w_alu_we;

    assign wb_result  = r_wb_result;
    assign wb_rd_addr = r_wb_rd;
    assign wb_we      = r_wb_we;

    // Operand select: own registered result beats the writeback bypass
    always_comb begin
        w_op_a = ex_rs1_data;
        if (r_wb_we && (r_wb_rd == ex_rs1_addr)) begin
            w_op_a = r_wb_result;
        end else if (fwd_we && (fwd_addr == ex_rs1_addr)) begin
            w_op_a = fwd_data;
        end
        w_rs2_fwd = ex_rs2_data;
        if (r_wb_we && (r_wb_rd == ex_rs2_addr)) begin
            w_rs2_fwd = r_wb_result;
        end else if (fwd_we && (fwd_addr == ex_rs2_addr)) begin
            w_rs2_fwd = fwd_data;
        end
        w_op_b = ex_use_imm ? ex_imm_ext : w_rs2_fwd;
    end

    // Single-cycle ALU; NOP, MUL and unknown codes give 0 with no write
    always_comb begin
        w_alu    = '0;
        w_alu_we = ex_we;
        case (ex_alu_op)
            OP_ADD:  w_alu = w_op_a + w_op_b;
            OP_SUB:  w_alu = w_op_a - w_op_b;
            OP_AND:  w_alu = w_op_a & w_op_b;
            OP_OR:   w_alu = w_op_a | w_op_b;
            OP_XOR:  w_alu = w_op_a ^ w_op_b;
            OP_SHL:  w_alu = w_op_a << w_op_b[SW-1:0];
            OP_SHR:  w_alu = w_op_a >> w_op_b[SW-1:0];
            default: begin
                w_alu    = '0;
                w_alu_we = 1'b0;
            end
        endcase
    end

`ifdef QTPA_MUL_EN

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_RUN  = 2'd1;
    localparam logic [1:0] S_MUL_DONE = 2'd2;

    localparam logic [SW-1:0] CNT_LAST = SW'(DATA_WIDTH - 1);

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_mcand;
    logic [DATA_WIDTH-1:0] r_mplier;
    logic [DATA_WIDTH-1:0] r_acc;
    logic [SW-1:0]         r_cnt;
    logic                  w_is_mul;

    assign w_is_mul = (ex_alu_op == OP_MUL);

    // Stall upstream while a MUL is being accepted or iterating
    always_comb begin
        ex_busy = 1'b0;
        if (!flush) begin
            ex_busy = ((r_state == S_IDLE) && w_is_mul)
                   || (r_state == S_MUL_RUN);
        end
    end

    // Writeback register plus multiplier sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wb_result <= '0;
            r_wb_rd     <= '0;
            r_wb_we     <= 1'b0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_wb_we <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_mul) begin
                        r_mcand  <= w_op_a;
                        r_mplier <= w_op_b;
                        r_acc    <= '0;
                        r_cnt    <= '0;
                        r_wb_we  <= 1'b0;
                        r_state  <= S_MUL_RUN;
                    end else begin
                        r_wb_result <= w_alu;
                        r_wb_rd     <= ex_rd_addr;
                        r_wb_we     <= w_alu_we;
                    end
                end
                S_MUL_RUN: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + SW'(1);
                    r_wb_we  <= 1'b0;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_MUL_DONE;
                    end
                end
                S_MUL_DONE: begin
                    r_wb_result <= r_acc;
                    r_wb_rd     <= ex_rd_addr;
                    r_wb_we     <= ex_we;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_wb_we <= 1'b0;
                end
            endcase
        end
    end

`else

    assign ex_busy = 1'b0;

    // Writeback register for single-cycle ops only
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_result <= '0;
            r_wb_rd     <= '0;
            r_wb_we     <= 1'b0;
        end else if (flush) begin
            r_wb_we <= 1'b0;
        end else begin
            r_wb_result <= w_alu;
            r_wb_rd     <= ex_rd_addr;
            r_wb_we     <= w_alu_we;
        end
    end

`endif

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed and random checks of ex_stage against a
// behavioural model of bypass, ALU and multiply rules.
module tb_ex_stage;
    import qtpa_pkg::*;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    op_t           ex_alu_op;
    logic [3:0]    ex_rd_addr;
    logic          ex_we;
    logic [DW-1:0] ex_imm_ext;
    logic          ex_use_imm;
    logic [DW-1:0] ex_rs1_data;
    logic [DW-1:0] ex_rs2_data;
    logic [3:0]    ex_rs1_addr;
    logic [3:0]    ex_rs2_addr;
    logic          fwd_we;
    logic [3:0]    fwd_addr;
    logic [DW-1:0] fwd_data;
    logic          ex_busy;
    logic [DW-1:0] wb_result;
    logic [3:0]    wb_rd_addr;
    logic          wb_we;

    int n_chk  = 0;
    int n_fail = 0;

    // model of the registered writeback outputs
    logic [DW-1:0] m_res;
    logic [3:0]    m_rd;
    logic          m_we;

    ex_stage #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .ex_alu_op(ex_alu_op), .ex_rd_addr(ex_rd_addr), .ex_we(ex_we),
        .ex_imm_ext(ex_imm_ext), .ex_use_imm(ex_use_imm),
        .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
        .ex_rs1_addr(ex_rs1_addr), .ex_rs2_addr(ex_rs2_addr),
        .fwd_we(fwd_we), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
        .ex_busy(ex_busy), .wb_result(wb_result),
        .wb_rd_addr(wb_rd_addr), .wb_we(wb_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [DW-1:0] obs,
                         input logic [DW-1:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] opnd(input logic [3:0] ad,
                                            input logic [DW-1:0] d);
        if (m_we && m_rd == ad) return m_res;
        if (fwd_we && fwd_addr == ad) return fwd_data;
        return d;
    endfunction

    function automatic logic [DW-1:0] ref_alu(input op_t op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        longint unsigned prod;
        int sh;
        sh = int'(b % DW);
        case (op)
            OP_ADD: return a + b;
            OP_SUB: return a - b;
            OP_AND: return a & b;
            OP_OR:  return a | b;
            OP_XOR: return a ^ b;
            OP_SHL: return a << sh;
            OP_SHR: return a >> sh;
`ifdef QTPA_MUL_EN
            OP_MUL: begin
                prod = longint'(a) * longint'(b);
                return prod[DW-1:0];
            end
`endif
            default: return '0;
        endcase
    endfunction

    function automatic logic ref_we(input op_t op, input logic we);
        if (op == OP_NOP) return 1'b0;
        if (op > OP_MUL) return 1'b0;
`ifndef QTPA_MUL_EN
        if (op == OP_MUL) return 1'b0;
`endif
        return we;
    endfunction

    // one single-cycle op: drive, check stall, check registered result
    task automatic do_op(input op_t op, input logic [3:0] r1a,
                         input logic [DW-1:0] r1d, input logic [3:0] r2a,
                         input logic [DW-1:0] r2d, input logic [DW-1:0] imm,
                         input logic ui, input logic [3:0] rd,
                         input logic we, input logic fwe,
                         input logic [3:0] fa, input logic [DW-1:0] fd,
                         input string tag);
        logic [DW-1:0] a, b, exp_r;
        logic exp_w;
        flush = 1'b0;
        ex_alu_op = op; ex_rs1_addr = r1a; ex_rs1_data = r1d;
        ex_rs2_addr = r2a; ex_rs2_data = r2d; ex_imm_ext = imm;
        ex_use_imm = ui; ex_rd_addr = rd; ex_we = we;
        fwd_we = fwe; fwd_addr = fa; fwd_data = fd;
        a = opnd(r1a, r1d);
        b = ui ? imm : opnd(r2a, r2d);
        exp_r = ref_alu(op, a, b);
        exp_w = ref_we(op, we);
        #1;
        check({tag, "_busy"}, DW'(ex_busy), '0);
        @(posedge clk); #1;
        check({tag, "_res"}, wb_result, exp_r);
        check({tag, "_we"}, DW'(wb_we), DW'(exp_w));
        if (exp_w) check({tag, "_rd"}, DW'(wb_rd_addr), DW'(rd));
        m_res = exp_r; m_rd = rd; m_we = exp_w;
    endtask

`ifdef QTPA_MUL_EN
    // full multiply with operands held until the result edge
    task automatic do_mul(input logic [3:0] r1a, input logic [DW-1:0] r1d,
                          input logic [3:0] r2a, input logic [DW-1:0] r2d,
                          input logic [3:0] rd, input logic we,
                          input string tag);
        logic [DW-1:0] a, b, p;
        int bc, bad;
        flush = 1'b0; fwd_we = 1'b0;
        ex_alu_op = OP_MUL; ex_rs1_addr = r1a; ex_rs1_data = r1d;
        ex_rs2_addr = r2a; ex_rs2_data = r2d; ex_use_imm = 1'b0;
        ex_rd_addr = rd; ex_we = we;
        a = opnd(r1a, r1d);
        b = opnd(r2a, r2d);
        p = ref_alu(OP_MUL, a, b);
        bc = 0; bad = 0;
        for (int e = 1; e <= DW + 2; e++) begin
            #1;
            if (ex_busy) bc++;
            if (e == DW + 2) check({tag, "_done_busy"}, DW'(ex_busy), '0);
            @(posedge clk); #1;
            if (e < DW + 2 && wb_we) bad++;
        end
        check({tag, "_busy_cycles"}, DW'(bc), DW'(DW + 1));
        check({tag, "_early_we"}, DW'(bad), '0);
        check({tag, "_res"}, wb_result, p);
        check({tag, "_we"}, DW'(wb_we), DW'(we));
        check({tag, "_rd"}, DW'(wb_rd_addr), DW'(rd));
        m_res = p; m_rd = rd; m_we = we;
    endtask
`endif

    // hold NOP for n edges and count any writeback
    task automatic quiet(input int n, input string tag);
        int bad;
        bad = 0;
        ex_alu_op = OP_NOP; flush = 1'b0; fwd_we = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (wb_we) bad++;
        end
        check({tag, "_no_we"}, DW'(bad), '0);
        m_we = 1'b0; m_res = '0;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; ex_alu_op = OP_MUL;
        ex_rd_addr = '0; ex_we = 1'b0; ex_imm_ext = '0; ex_use_imm = 1'b0;
        ex_rs1_data = '0; ex_rs2_data = '0; ex_rs1_addr = '0;
        ex_rs2_addr = '0; fwd_we = 1'b0; fwd_addr = '0; fwd_data = '0;
        m_res = '0; m_rd = '0; m_we = 1'b0;
        #2;
        check("rst_res", wb_result, '0);
        check("rst_rd", DW'(wb_rd_addr), '0);
        check("rst_we", DW'(wb_we), '0);
`ifdef QTPA_MUL_EN
        check("rst_busy_mul", DW'(ex_busy), 1);
`else
        check("rst_busy_mul", DW'(ex_busy), '0);
`endif
        ex_alu_op = OP_NOP;
        #1;
        check("rst_busy_nop", DW'(ex_busy), '0);
        @(negedge clk); rst_n = 1'b1;

        do_op(OP_ADD, 1, 5, 2, 7, 0, 0, 3, 1, 0, 0, 0, "add");
        check("add_const", wb_result, 12);
        do_op(OP_SUB, 1, 0, 2, 1, 0, 0, 5, 1, 0, 0, 0, "sub");
        check("sub_const", wb_result, 32'hFFFF_FFFF);
        do_op(OP_SHL, 1, 1, 2, 33, 0, 0, 6, 1, 0, 0, 0, "shl");
        check("shl_const", wb_result, 2);
        do_op(OP_ADD, 1, 5, 2, 5, 0, 0, 4, 1, 0, 0, 0, "add10");
        do_op(OP_ADD, 4, 0, 2, 0, 1, 1, 7, 1, 1, 4, 99, "bypass");
        check("bypass_const", wb_result, 11);
        do_op(OP_OR, 9, 0, 2, 0, 1, 1, 8, 1, 1, 9, 99, "fwd_ext");
        check("fwd_ext_const", wb_result, 99);
        do_op(OP_SHR, 1, 32'h8000_0000, 2, 31, 0, 0, 2, 1, 0, 0, 0, "shr");
        check("shr_const", wb_result, 1);
        do_op(OP_NOP, 1, 3, 2, 4, 0, 0, 2, 1, 0, 0, 0, "nop");

        flush = 1'b1; ex_alu_op = OP_ADD; ex_we = 1'b1;
        @(posedge clk); #1;
        check("flush_alu_we", DW'(wb_we), '0);
        m_we = 1'b0;

`ifdef QTPA_MUL_EN
        do_mul(1, 123, 2, 456, 3, 1, "mul");
        check("mul_const", wb_result, 56088);
        do_op(OP_ADD, 3, 0, 2, 0, 1, 1, 4, 1, 0, 0, 0, "mul_dep");
        check("mul_dep_const", wb_result, 56089);
        do_mul(1, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 5, 1, "mul_wrap");
        do_mul(5, 0, 2, 3, 6, 1, "mul_b2b");
        do_op(OP_XOR, 6, 0, 2, 0, 32'hFF, 1, 7, 1, 0, 0, 0, "b2b_dep");

        ex_alu_op = OP_MUL; ex_rs1_addr = 1; ex_rs1_data = 7;
        ex_rs2_addr = 2; ex_rs2_data = 9; ex_use_imm = 1'b0;
        ex_rd_addr = 8; ex_we = 1'b1;
        repeat (5) @(posedge clk);
        #1; flush = 1'b1; #1;
        check("flush_busy", DW'(ex_busy), '0);
        @(posedge clk); #1;
        check("flush_we", DW'(wb_we), '0);
        m_we = 1'b0;
        do_op(OP_ADD, 1, 20, 2, 22, 0, 0, 9, 1, 0, 0, 0, "post_flush");
        check("post_flush_const", wb_result, 42);
        quiet(40, "post_flush");

        ex_alu_op = OP_MUL; ex_rs1_data = 11; ex_rs2_data = 13;
        repeat (10) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; #1;
        check("midrst_res", wb_result, '0);
        check("midrst_we", DW'(wb_we), '0);
        check("midrst_busy", DW'(ex_busy), 1);
        ex_alu_op = OP_NOP;
        @(negedge clk); rst_n = 1'b1;
        m_rd = '0;
        quiet(40, "midrst");
        check("midrst_res_after", wb_result, '0);
`else
        do_op(OP_MUL, 1, 3, 2, 4, 0, 0, 3, 1, 0, 0, 0, "mul_off");
        check("mul_off_const", wb_result, '0);
`endif

        for (int i = 0; i < 200; i++) begin
`ifdef QTPA_MUL_EN
            op_t op = op_t'($urandom_range(0, 7));
`else
            op_t op = op_t'($urandom_range(0, 8));
`endif
            do_op(op, 4'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 3)), $urandom, $urandom,
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 3)), $urandom, "rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
